// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants and stage bundle types for pipeline stage registers
//   PIPE_BUBBLE_CTRL : fill bit for control fields of a bubble (all zero)
//   *_CTRL_W/*_DATA_W: packed widths of each stage boundary bundle
package pipe_pkg;

    localparam logic PIPE_BUBBLE_CTRL = 1'b0;

    typedef struct packed {
        logic        MemToReg;
        logic [1:0]  BitsIn;
        logic        Jal_Mux;
        logic [1:0]  SEL_Madd;
        logic        HiLo_WB;
        logic        RegWrite;
        logic        WriteDataHi;
        logic        WriteDataLo;
        logic        minRegWrite;
    } x3_wb_ctrl_t;

    typedef struct packed {
        logic [31:0] pc_plus4;
        logic [31:0] alu_result;
        logic [31:0] mem_data;
        logic [31:0] hi_value;
        logic [31:0] lo_value;
        logic [4:0]  write_reg;
    } x3_wb_data_t;

    typedef struct packed {
        logic        valid_fetch;
        logic        branch_pred;
    } if_id_ctrl_t;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc_plus4;
    } if_id_data_t;

    localparam int X3_WB_CTRL_W = $bits(x3_wb_ctrl_t);
    localparam int X3_WB_DATA_W = $bits(x3_wb_data_t);
    localparam int IF_ID_CTRL_W = $bits(if_id_ctrl_t);
    localparam int IF_ID_DATA_W = $bits(if_id_data_t);

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one valid/data/ctrl holding register of a pipeline stage
//   Clk, Reset     : clock, synchronous active-high reset (clears everything)
//   load           : capture d_data/d_ctrl and set valid
//   clr_valid      : drop the held entry (ignored while load)
//   clr_ctrl       : zero the control field; data is left untouched
//   d_data, d_ctrl : incoming entry
//   q_valid, q_data, q_ctrl : held entry
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W = 192,
    parameter int CTRL_W = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              load,
    input  logic              clr_valid,
    input  logic              clr_ctrl,
    input  logic [DATA_W-1:0] d_data,
    input  logic [CTRL_W-1:0] d_ctrl,
    output logic              q_valid,
    output logic [DATA_W-1:0] q_data,
    output logic [CTRL_W-1:0] q_ctrl
);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            q_valid <= 1'b0;
            q_data  <= '0;
            q_ctrl  <= {CTRL_W{PIPE_BUBBLE_CTRL}};
        end else if (load) begin
            q_valid <= 1'b1;
            q_data  <= d_data;
            q_ctrl  <= d_ctrl;
        end else begin
            if (clr_valid) begin
                q_valid <= 1'b0;
            end
            if (clr_ctrl) begin
                q_ctrl <= {CTRL_W{PIPE_BUBBLE_CTRL}};
            end
        end
    end

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// rtl/pipe_stage_skid_reg.sv - generic pipeline stage register with optional skid slot
//   Clk, Reset          : clock, synchronous active-high reset
//   flush               : kill held entries, stage becomes a bubble
//   in_valid/in_ready   : upstream handshake; in_data/in_ctrl upstream entry
//   out_valid/out_ready : downstream handshake; out_data/out_ctrl head entry
//   stall_count         : saturating count of cycles held with out_ready low
module pipe_stage_skid_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 192,
    parameter int CTRL_W = 16,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_count
);

    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic [CTRL_W-1:0] m_ctrl;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic [CTRL_W-1:0] s_ctrl;

    logic              accept;
    logic              m_free;
    logic              m_load;
    logic              m_clr_valid;
    logic [DATA_W-1:0] m_d_data;
    logic [CTRL_W-1:0] m_d_ctrl;

    assign accept = in_valid & in_ready;
    // M can take a new entry when empty or when its entry leaves this cycle.
    assign m_free = !m_valid | out_ready;

    // S always has priority for refilling M so FIFO order is preserved;
    // in_ready is low while S is occupied, so no accept competes with it.
    assign m_load      = !flush & m_free & (s_valid | accept);
    assign m_clr_valid = flush | (m_free & !s_valid & !accept);
    assign m_d_data    = s_valid ? s_data : in_data;
    assign m_d_ctrl    = s_valid ? s_ctrl : in_ctrl;

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_m_slot (
        .Clk       (Clk),
        .Reset     (Reset),
        .load      (m_load),
        .clr_valid (m_clr_valid),
        .clr_ctrl  (flush),
        .d_data    (m_d_data),
        .d_ctrl    (m_d_ctrl),
        .q_valid   (m_valid),
        .q_data    (m_data),
        .q_ctrl    (m_ctrl)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic s_load;
            logic s_clr_valid;

            // Registered ready: the one extra entry that arrives after
            // out_ready drops lands in S, cutting the out_ready->in_ready path.
            assign in_ready    = !s_valid;
            assign s_load      = !flush & !m_free & accept;
            assign s_clr_valid = flush | (m_free & s_valid);

            pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_s_slot (
                .Clk       (Clk),
                .Reset     (Reset),
                .load      (s_load),
                .clr_valid (s_clr_valid),
                .clr_ctrl  (flush),
                .d_data    (in_data),
                .d_ctrl    (in_ctrl),
                .q_valid   (s_valid),
                .q_data    (s_data),
                .q_ctrl    (s_ctrl)
            );
        end else begin : g_no_skid
            assign in_ready = m_free;
            assign s_valid  = 1'b0;
            assign s_data   = '0;
            assign s_ctrl   = '0;
        end
    endgenerate

    assign out_valid = m_valid;
    assign out_data  = m_data;
    assign out_ctrl  = m_valid ? m_ctrl : {CTRL_W{PIPE_BUBBLE_CTRL}};

    // Counts stalled cycles for performance monitoring; flush leaves it alone.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            stall_count <= '0;
        end else if (m_valid && !out_ready && !(&stall_count)) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// tb/tb_pipe_stage_skid_reg.sv - self-checking bench for pipe_stage_skid_reg (both skid modes)
module tb_pipe_stage_skid_reg;

    localparam int DW = 32;
    localparam int CW = 8;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_ready;

    logic          in_ready_a, out_valid_a;
    logic [DW-1:0] out_data_a;
    logic [CW-1:0] out_ctrl_a;
    logic [3:0]    stall_count_a;

    logic          in_ready_b, out_valid_b;
    logic [DW-1:0] out_data_b;
    logic [CW-1:0] out_ctrl_b;
    logic [15:0]   stall_count_b;

    always #5 Clk = ~Clk;

    pipe_stage_skid_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(4)) dut_a (
        .Clk(Clk), .Reset(Reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .out_ctrl(out_ctrl_a), .stall_count(stall_count_a)
    );

    pipe_stage_skid_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(16)) dut_b (
        .Clk(Clk), .Reset(Reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .out_ctrl(out_ctrl_b), .stall_count(stall_count_b)
    );

    // Scoreboards: entries ({ctrl,data}) expected to be held, head first.
    logic [CW+DW-1:0] qa[$];
    logic [CW+DW-1:0] qb[$];
    int unsigned      ca, cb;
    int               total  = 0;
    int               passed = 0;
    logic [DW-1:0]    nxt;
    logic             acc_a, acc_b;

    function automatic logic [CW-1:0] ctrl_of(input logic [DW-1:0] d);
        return d[CW-1:0] ^ 8'h3C;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_all();
        chk("a_out_valid", {63'd0, out_valid_a}, {63'd0, qa.size() > 0});
        chk("a_in_ready", {63'd0, in_ready_a}, {63'd0, qa.size() < 2});
        chk("a_stall_count", {60'd0, stall_count_a}, 64'(ca));
        if (qa.size() > 0) begin
            chk("a_out_data", {32'd0, out_data_a}, {32'd0, qa[0][DW-1:0]});
            chk("a_out_ctrl", {56'd0, out_ctrl_a}, {56'd0, qa[0][CW+DW-1:DW]});
        end else begin
            chk("a_bubble_ctrl", {56'd0, out_ctrl_a}, 64'd0);
        end
        chk("b_out_valid", {63'd0, out_valid_b}, {63'd0, qb.size() > 0});
        chk("b_in_ready", {63'd0, in_ready_b}, {63'd0, (qb.size() == 0) || out_ready});
        chk("b_stall_count", {48'd0, stall_count_b}, 64'(cb));
        if (qb.size() > 0) begin
            chk("b_out_data", {32'd0, out_data_b}, {32'd0, qb[0][DW-1:0]});
            chk("b_out_ctrl", {56'd0, out_ctrl_b}, {56'd0, qb[0][CW+DW-1:DW]});
        end else begin
            chk("b_bubble_ctrl", {56'd0, out_ctrl_b}, 64'd0);
        end
    endtask

    // One clock: drive, update the reference queues at the edge, check at negedge.
    task automatic step(input logic v, input logic rdy, input logic fl, input logic rst);
        in_valid  = v;
        in_data   = nxt;
        in_ctrl   = ctrl_of(nxt);
        out_ready = rdy;
        flush     = fl;
        Reset     = rst;
        @(posedge Clk);
        acc_a = 1'b0;
        acc_b = 1'b0;
        if (rst) begin
            qa.delete();
            qb.delete();
            ca = 0;
            cb = 0;
        end else begin
            if (qa.size() > 0 && !rdy && ca != 15) ca++;
            if (qb.size() > 0 && !rdy && cb != 65535) cb++;
            acc_a = v && (qa.size() < 2);
            acc_b = v && ((qb.size() == 0) || rdy);
            if (fl) begin
                qa.delete();
                qb.delete();
            end else begin
                if (qa.size() > 0 && rdy) void'(qa.pop_front());
                if (qb.size() > 0 && rdy) void'(qb.pop_front());
                if (acc_a) qa.push_back({ctrl_of(nxt), nxt});
                if (acc_b) qb.push_back({ctrl_of(nxt), nxt});
            end
        end
        @(negedge Clk);
        check_all();
        if (acc_a) nxt = nxt + 1;
    endtask

    initial begin
        nxt = 32'h0;
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("rst_out_valid", {63'd0, out_valid_a}, 64'd0);
        chk("rst_out_data", {32'd0, out_data_a}, 64'd0);
        chk("rst_out_ctrl", {56'd0, out_ctrl_a}, 64'd0);
        chk("rst_in_ready_a", {63'd0, in_ready_a}, 64'd1);
        chk("rst_in_ready_b", {63'd0, in_ready_b}, 64'd1);
        chk("rst_stall", {60'd0, stall_count_a}, 64'd0);

        // Single entry with one-cycle latency.
        nxt = 32'hA5A5_A5A5;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("lat_a5_data", {32'd0, out_data_a}, 64'hA5A5_A5A5);
        chk("lat_a5_valid", {63'd0, out_valid_a}, 64'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0);

        // Streaming 1..8, both modes, full throughput.
        nxt = 32'd1;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("stream_last_a", {32'd0, out_data_a}, 64'd8);
        chk("stream_last_b", {32'd0, out_data_b}, 64'd8);
        step(1'b0, 1'b1, 1'b0, 1'b0);

        // Back-pressure for 5 cycles during a stream.
        nxt = 32'h100;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            if (i == 0) chk("bp_ready_1st", {63'd0, in_ready_a}, 64'd0);
        end
        chk("bp_stall_5", {60'd0, stall_count_a}, 64'd5);
        chk("bp_head", {32'd0, out_data_a}, 64'h101);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0);

        // Flush with both slots full and an offered entry.
        nxt = 32'h200;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("flush_valid", {63'd0, out_valid_a}, 64'd0);
        chk("flush_ctrl", {56'd0, out_ctrl_a}, 64'd0);
        chk("flush_ready", {63'd0, in_ready_a}, 64'd1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0);

        // Saturation of the 4-bit counter; slots fill while stalled.
        nxt = 32'h300;
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("sat_15", {60'd0, stall_count_a}, 64'd15);

        // Reset mid-stall with both slots full.
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("mid_rst_valid", {63'd0, out_valid_a}, 64'd0);
        chk("mid_rst_data", {32'd0, out_data_a}, 64'd0);
        chk("mid_rst_ctrl", {56'd0, out_ctrl_a}, 64'd0);
        chk("mid_rst_stall", {60'd0, stall_count_a}, 64'd0);
        chk("mid_rst_ready", {63'd0, in_ready_a}, 64'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
